stream_io_intf: RTL and testbench
=================================

# stream_io_intf

Parametrised host-side I/O interface for the BLAKE2 core. It accepts a byte-lane command stream and decodes it into kk/nn/ll configuration fields and block-indexed message beats, with ready/valid backpressure towards the host. It also serialises the core's parallel digest into an nn-byte output stream under downstream backpressure. It sits between the tile pins and the hash core, and supports both BLAKE2s (32-byte block) and BLAKE2b (64-byte block) geometries and multi-byte buses.

## Interface
- BPB, 1: bytes per input beat; legal values 1, 2, 4.
- BB, 64: block size in bytes; a power of two, multiple of BPB.
- LL_BYTES, 8: byte width of the ll message-length field.
- NN_MAX, 64: maximum digest bytes; also the maximum legal kk.
- KN_W, 7: width of kk/nn; must hold NN_MAX.
- clk  in  1  clock; one domain.
- reset  in  1  asynchronous, active-high reset.
- en_i  in  1  slice enable; registered internally as en_q.
- valid_i  in  1  host beat valid.
- cmd_i  in  2  0=CONF, 1=START, 2=DATA, 3=LAST.
- data_i  in  8*BPB  beat payload; lane 0 = bits [7:0] = lowest byte index.
- ready_o  out  1  beat accepted when valid_i & ready_o.
- core_busy_i  in  1  core cannot take a message beat this cycle.
- kk_o, nn_o  out  KN_W  key / digest length.
- ll_o  out  8*LL_BYTES  message length, little-endian.
- cfg_err_o  out  1  configuration invalid.
- data_v_o  out  1  one-cycle message beat strobe.
- data_o  out  8*BPB  registered message beat.
- data_idx_o  out  log2(BB)  block byte offset of lane 0.
- block_first_o, block_last_o  out  1  current block is first / last of the message.
- hash_v_i  in  1  digest-ready pulse from core.
- hash_i  in  8*NN_MAX  parallel digest; byte 0 at [7:0].
- hash_v_o, hash_o[7:0], hash_last_o  out  serial digest byte stream.
- hash_ready_i  in  1  downstream accepts hash_o.

## Operation
- Acceptance: `acc = valid_i & ready_o`, with `ready_o = en_q & ~core_busy_i & (hstate==IDLE)`. A beat is ignored unless `acc`.
- CONF beats:
  - Only lane 0 is used. A byte counter cfg_cnt, saturating at 2+LL_BYTES, advances per CONF beat.
  - Byte 0 loads kk_o, byte 1 loads nn_o (zero-extended from [KN_W-1:0] of lane 0).
  - Bytes 2..2+LL_BYTES-1 shift into ll_o from the MSB end, giving little-endian order.
  - CONF beats beyond saturation are dropped, and the overflow is recorded.
  - Any CONF beat resets data_cnt and cfg_err_o to 0.
- Message beats (cmd != CONF):
  - The first message beat after CONF clears cfg_cnt.
  - On that first beat, cfg_err_o is set to 1 if any of these hold: cfg_cnt != 2+LL_BYTES, overflow occurred, nn_o == 0, nn_o > NN_MAX, or kk_o > NN_MAX.
  - data_cnt (log2(BB) bits) advances by BPB per message beat and wraps mod BB.
  - data_idx_o is data_cnt before the increment.
  - block_first_o and block_last_o are updated only on a beat at offset 0:
    - first = (cmd==START)
    - last = (cmd==LAST)
    - both are held until the next offset-0 beat.
  - START or LAST at a non-zero offset is treated as DATA.
- Hash serialiser FSM:
  - IDLE: on hash_v_i with 1 <= nn_o:
    - load shift register from hash_i;
    - set rem = min(nn_o, NN_MAX);
    - go to SHIFT.
  - IDLE: hash_v_i with nn_o == 0 is ignored.
  - SHIFT: hash_v_o = 1, hash_o = byte 0 of the shift register, hash_last_o = (rem == 1).
  - SHIFT, on hash_ready_i: shift right by 8, decrement rem; when rem == 1, return to IDLE.
  - hash_v_i is ignored while in SHIFT. The serialiser is not gated by en_q.
- Reset: every output and state element is 0, including kk/nn/ll and hstate = IDLE. Reset mid-operation aborts any partial config, block, or digest.

## Timing
- en_i to en_q: 1 cycle; ready_o is combinational from en_q, core_busy_i and hstate.
- Message beat accepted at cycle t: data_v_o = 1 at t+1 only. data_o, data_idx_o and the block flags are valid at t+1 and held until the next message beat.
- CONF beat at t: the field is updated at t+1. cfg_err_o updates at t+1 after the first message beat.
- hash_v_i at t: hash_v_o = 1 from t+1; each byte is held until hash_ready_i. With hash_ready_i tied high, nn bytes take nn cycles.
- Back-to-back accepted beats: data_v_o is high every cycle.

## Test plan
- Config, BPB=1: CONF 0x20, 0x40, 03 00 00 00 00 00 00 00. Expect kk_o=32, nn_o=64, ll_o=3; first DATA beat gives cfg_err_o=0.
- Block indexing, BPB=4, BB=64: START + 15 DATA beats, then LAST + 15 DATA. Expect data_idx_o 0,4..60,0; block_first_o=1 for beats 1-16, then 0; block_last_o=1 for beats 17-32.
- Backpressure: core_busy_i=1 for 3 cycles with valid_i held. Expect ready_o=0, no data_v_o, no counter movement; resumes the cycle core_busy_i falls.
- Error: 3 ll bytes only, then DATA. Expect cfg_err_o=1; next CONF beat clears it to 0.
- Digest: nn=4, hash_i[31:0]=0x44332211, hash_ready_i toggling 1,0,1,1,1. Expect hash_o sequence 11,22,33,44, hash_last_o on 0x44, ready_o=0 throughout SHIFT.
- Async reset asserted mid-SHIFT and mid-block. Expect all outputs 0 immediately; next hash_v_i restarts from byte 0.

Source files
------------

// File: rtl/stream_io_intf.sv
// stream_io_intf: host-side byte-lane command decoder and digest serialiser
// for the BLAKE2 core. CONF beats load kk/nn/ll. Message beats are forwarded
// with their block byte offset and first/last-block flags. The core's
// parallel digest is streamed out one byte at a time, under backpressure.
module stream_io_intf #(
  parameter int BPB      = 1,
  parameter int BB       = 64,
  parameter int LL_BYTES = 8,
  parameter int NN_MAX   = 64,
  parameter int KN_W     = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic [1:0]              cmd_i,
  input  logic [8*BPB-1:0]        data_i,
  output logic                    ready_o,
  input  logic                    core_busy_i,
  output logic [KN_W-1:0]         kk_o,
  output logic [KN_W-1:0]         nn_o,
  output logic [8*LL_BYTES-1:0]   ll_o,
  output logic                    cfg_err_o,
  output logic                    data_v_o,
  output logic [8*BPB-1:0]        data_o,
  output logic [$clog2(BB)-1:0]   data_idx_o,
  output logic                    block_first_o,
  output logic                    block_last_o,
  input  logic                    hash_v_i,
  input  logic [8*NN_MAX-1:0]     hash_i,
  output logic                    hash_v_o,
  output logic [7:0]              hash_o,
  output logic                    hash_last_o,
  input  logic                    hash_ready_i
);

  localparam int IDX_W = $clog2(BB);
  localparam int CFG_N = 2 + LL_BYTES;
  localparam int CC_W  = $clog2(CFG_N + 1);

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_LAST  = 2'd3;

  localparam logic [0:0] H_IDLE  = 1'b0;
  localparam logic [0:0] H_SHIFT = 1'b1;

  logic                  en_q;
  logic [0:0]            hstate_q, hstate_d;
  logic [CC_W-1:0]       cfg_cnt_q, cfg_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  in_msg_q, in_msg_d;
  logic [KN_W-1:0]       kk_q, kk_d, nn_q, nn_d;
  logic [8*LL_BYTES-1:0] ll_q, ll_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  data_v_q, data_v_d;
  logic [8*BPB-1:0]      data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d, cnt_q, cnt_d;
  logic                  first_q, first_d, last_q, last_d;
  logic [8*NN_MAX-1:0]   sh_q, sh_d;
  logic [KN_W-1:0]       rem_q, rem_d;

  logic       acc;
  logic [7:0] lane0;

  assign ready_o = en_q & ~core_busy_i & (hstate_q == H_IDLE);
  assign acc     = valid_i & ready_o;
  assign lane0   = data_i[7:0];

  // Command decode: config field loading and message beat bookkeeping
  always_comb begin
    cfg_cnt_d = cfg_cnt_q;
    ovf_d     = ovf_q;
    in_msg_d  = in_msg_q;
    kk_d      = kk_q;
    nn_d      = nn_q;
    ll_d      = ll_q;
    cfg_err_d = cfg_err_q;
    data_v_d  = 1'b0;
    data_d    = data_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    last_d    = last_q;
    if (acc) begin
      if (cmd_i == CMD_CONF) begin
        cnt_d     = '0;
        cfg_err_d = 1'b0;
        in_msg_d  = 1'b0;
        if (cfg_cnt_q < CC_W'(CFG_N)) begin
          cfg_cnt_d = cfg_cnt_q + CC_W'(1);
          if (cfg_cnt_q == '0)
            kk_d = lane0[KN_W-1:0];
          else if (cfg_cnt_q == CC_W'(1))
            nn_d = lane0[KN_W-1:0];
          else
            ll_d = {lane0, ll_q[8*LL_BYTES-1:8]};
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        if (!in_msg_q) begin
          // Validate the configuration once, on the first message beat
          in_msg_d  = 1'b1;
          cfg_cnt_d = '0;
          ovf_d     = 1'b0;
          cfg_err_d = (cfg_cnt_q != CC_W'(CFG_N)) | ovf_q | (nn_q == '0) |
                      (nn_q > KN_W'(NN_MAX)) | (kk_q > KN_W'(NN_MAX));
        end
        data_v_d = 1'b1;
        data_d   = data_i;
        idx_d    = cnt_q;
        cnt_d    = cnt_q + IDX_W'(BPB);
        if (cnt_q == '0) begin
          first_d = (cmd_i == CMD_START);
          last_d  = (cmd_i == CMD_LAST);
        end
      end
    end
  end

  // Digest serialiser next state; runs regardless of en_q
  always_comb begin
    hstate_d = hstate_q;
    sh_d     = sh_q;
    rem_d    = rem_q;
    if (hstate_q == H_IDLE) begin
      if (hash_v_i && (nn_q != '0)) begin
        sh_d     = hash_i;
        rem_d    = (nn_q > KN_W'(NN_MAX)) ? KN_W'(NN_MAX) : nn_q;
        hstate_d = H_SHIFT;
      end
    end else if (hash_ready_i) begin
      sh_d  = {8'h00, sh_q[8*NN_MAX-1:8]};
      rem_d = rem_q - KN_W'(1);
      if (rem_q == KN_W'(1))
        hstate_d = H_IDLE;
    end
  end

  // State registers; reset clears every field, aborting partial work
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b0;
      hstate_q  <= H_IDLE;
      cfg_cnt_q <= '0;
      ovf_q     <= 1'b0;
      in_msg_q  <= 1'b0;
      kk_q      <= '0;
      nn_q      <= '0;
      ll_q      <= '0;
      cfg_err_q <= 1'b0;
      data_v_q  <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      sh_q      <= '0;
      rem_q     <= '0;
    end else begin
      en_q      <= en_i;
      hstate_q  <= hstate_d;
      cfg_cnt_q <= cfg_cnt_d;
      ovf_q     <= ovf_d;
      in_msg_q  <= in_msg_d;
      kk_q      <= kk_d;
      nn_q      <= nn_d;
      ll_q      <= ll_d;
      cfg_err_q <= cfg_err_d;
      data_v_q  <= data_v_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      last_q    <= last_d;
      sh_q      <= sh_d;
      rem_q     <= rem_d;
    end
  end

  assign kk_o          = kk_q;
  assign nn_o          = nn_q;
  assign ll_o          = ll_q;
  assign cfg_err_o     = cfg_err_q;
  assign data_v_o      = data_v_q;
  assign data_o        = data_q;
  assign data_idx_o    = idx_q;
  assign block_first_o = first_q;
  assign block_last_o  = last_q;
  assign hash_v_o      = (hstate_q == H_SHIFT);
  assign hash_o        = sh_q[7:0];
  assign hash_last_o   = (hstate_q == H_SHIFT) && (rem_q == KN_W'(1));

endmodule

// File: tb/tb_stream_io_intf.sv
// Directed bench for stream_io_intf with a 4-byte bus and 64-byte blocks.
module tb_stream_io_intf;

  localparam int BPB = 4, BB = 64, LL_BYTES = 8, NN_MAX = 64, KN_W = 7;
  localparam logic [1:0] CONF = 2'd0, START = 2'd1, DATA = 2'd2, LAST = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_i = 1'b0, valid_i = 1'b0, core_busy_i = 1'b0;
  logic [1:0] cmd_i = 2'd0;
  logic [8*BPB-1:0] data_i = '0;
  logic ready_o, cfg_err_o, data_v_o, block_first_o, block_last_o;
  logic [KN_W-1:0] kk_o, nn_o;
  logic [8*LL_BYTES-1:0] ll_o;
  logic [8*BPB-1:0] data_o;
  logic [$clog2(BB)-1:0] data_idx_o;
  logic hash_v_i = 1'b0, hash_ready_i = 1'b0;
  logic [8*NN_MAX-1:0] hash_i = '0;
  logic hash_v_o, hash_last_o;
  logic [7:0] hash_o;

  int n_vec = 0;
  int n_err = 0;

  stream_io_intf #(.BPB(BPB), .BB(BB), .LL_BYTES(LL_BYTES), .NN_MAX(NN_MAX), .KN_W(KN_W)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .valid_i(valid_i), .cmd_i(cmd_i),
    .data_i(data_i), .ready_o(ready_o), .core_busy_i(core_busy_i),
    .kk_o(kk_o), .nn_o(nn_o), .ll_o(ll_o), .cfg_err_o(cfg_err_o),
    .data_v_o(data_v_o), .data_o(data_o), .data_idx_o(data_idx_o),
    .block_first_o(block_first_o), .block_last_o(block_last_o),
    .hash_v_i(hash_v_i), .hash_i(hash_i), .hash_v_o(hash_v_o),
    .hash_o(hash_o), .hash_last_o(hash_last_o), .hash_ready_i(hash_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one accepted beat; called on a falling edge, returns on the next
  task automatic send(input logic [1:0] c, input logic [31:0] d);
    valid_i = 1'b1; cmd_i = c; data_i = d;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic do_config(input logic [7:0] k, input logic [7:0] n, input int nll,
                           input logic [63:0] llv);
    send(CONF, {24'h0, k});
    send(CONF, {24'h0, n});
    for (int i = 0; i < nll; i++) send(CONF, {24'h0, llv[8*i +: 8]});
  endtask

  logic rdy_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] exp_b;
  int bi;

  initial begin
    // reset state
    @(negedge clk);
    chk_eq("rst_kk", 64'(kk_o), 0);
    chk_eq("rst_nn", 64'(nn_o), 0);
    chk_eq("rst_ll", ll_o, 0);
    chk_eq("rst_dv", 64'(data_v_o), 0);
    chk_eq("rst_hv", 64'(hash_v_o), 0);
    chk_eq("rst_rdy", 64'(ready_o), 0);
    reset = 1'b0; en_i = 1'b1;
    @(negedge clk);
    chk_eq("en_rdy", 64'(ready_o), 1);

    // basic config
    do_config(8'h20, 8'h40, 8, 64'h3);
    chk_eq("cfg_kk", 64'(kk_o), 32);
    chk_eq("cfg_nn", 64'(nn_o), 64);
    chk_eq("cfg_ll", ll_o, 3);
    chk_eq("cfg_dv_conf", 64'(data_v_o), 0);
    send(DATA, 32'hAABBCCDD);
    chk_eq("cfg_err_ok", 64'(cfg_err_o), 0);
    chk_eq("d1_dv", 64'(data_v_o), 1);
    chk_eq("d1_data", 64'(data_o), 64'hAABBCCDD);
    chk_eq("d1_idx", 64'(data_idx_o), 0);
    @(negedge clk);
    chk_eq("d1_dv_pulse", 64'(data_v_o), 0);

    // block indexing: START + 15 DATA, LAST + 15 DATA, then wrap
    do_config(8'h20, 8'h40, 8, 64'h3);
    for (int i = 1; i <= 32; i++) begin
      send((i == 1) ? START : (i == 17) ? LAST : DATA, 32'(i));
      chk_eq("blk_dv", 64'(data_v_o), 1);
      chk_eq("blk_data", 64'(data_o), 64'(i));
      chk_eq("blk_idx", 64'(data_idx_o), 64'(((i - 1) * 4) % 64));
      chk_eq("blk_first", 64'(block_first_o), (i <= 16) ? 64'd1 : 64'd0);
      chk_eq("blk_last", 64'(block_last_o), (i >= 17) ? 64'd1 : 64'd0);
    end
    chk_eq("blk_err", 64'(cfg_err_o), 0);
    send(DATA, 32'h33);
    chk_eq("wrap_idx", 64'(data_idx_o), 0);
    chk_eq("wrap_first", 64'(block_first_o), 0);
    chk_eq("wrap_last", 64'(block_last_o), 0);

    // backpressure
    core_busy_i = 1'b1; valid_i = 1'b1; cmd_i = DATA; data_i = 32'h77;
    #1 chk_eq("bp_rdy_comb", 64'(ready_o), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("bp_rdy", 64'(ready_o), 0);
      chk_eq("bp_dv", 64'(data_v_o), 0);
      chk_eq("bp_idx_hold", 64'(data_idx_o), 0);
    end
    core_busy_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    chk_eq("bp_resume_dv", 64'(data_v_o), 1);
    chk_eq("bp_resume_idx", 64'(data_idx_o), 4);
    chk_eq("bp_resume_data", 64'(data_o), 64'h77);

    // short ll field
    do_config(8'h20, 8'h40, 3, 64'h070605);
    chk_eq("short_ll", ll_o, 64'h0706050000000000);
    send(DATA, 32'h1);
    chk_eq("short_err", 64'(cfg_err_o), 1);
    send(CONF, 32'h21);
    chk_eq("short_clr", 64'(cfg_err_o), 0);
    chk_eq("short_kk", 64'(kk_o), 64'h21);

    // overflowing CONF beats
    send(DATA, 32'h1);
    do_config(8'h10, 8'h20, 8, 64'h0102030405060708);
    send(CONF, 32'hEE);
    chk_eq("ovf_ll", ll_o, 64'h0102030405060708);
    chk_eq("ovf_kk", 64'(kk_o), 64'h10);
    send(DATA, 32'h1);
    chk_eq("ovf_err", 64'(cfg_err_o), 1);

    // nn above maximum
    do_config(8'h00, 8'd65, 8, 64'h0);
    send(DATA, 32'h1);
    chk_eq("nnmax_err", 64'(cfg_err_o), 1);

    // digest serialisation, nn = 4
    do_config(8'h00, 8'h04, 8, 64'h0);
    hash_i = '0; hash_i[39:0] = 40'h5544332211;
    hash_v_i = 1'b1;
    @(negedge clk);
    hash_v_i = 1'b0;
    bi = 0;
    for (int k = 0; k < 5; k++) begin
      exp_b = 8'(8'h11 * (bi + 1));
      chk_eq("dig_hv", 64'(hash_v_o), 1);
      chk_eq("dig_byte", 64'(hash_o), 64'(exp_b));
      chk_eq("dig_last", 64'(hash_last_o), (bi == 3) ? 64'd1 : 64'd0);
      chk_eq("dig_rdy", 64'(ready_o), 0);
      if (k == 1) begin
        hash_v_i = 1'b1; hash_i[31:0] = 32'hDEADBEEF;
      end
      hash_ready_i = rdy_seq[k];
      @(negedge clk);
      hash_v_i = 1'b0;
      if (rdy_seq[k]) bi++;
    end
    chk_eq("dig_done_hv", 64'(hash_v_o), 0);
    chk_eq("dig_done_rdy", 64'(ready_o), 1);
    hash_i[31:0] = 32'h44332211;

    // async reset mid-block and mid-SHIFT
    send(START, 32'h5);
    send(DATA, 32'h6);
    chk_eq("pre_first", 64'(block_first_o), 1);
    chk_eq("pre_idx", 64'(data_idx_o), 4);
    hash_v_i = 1'b1; hash_ready_i = 1'b0;
    @(negedge clk);
    hash_v_i = 1'b0; hash_ready_i = 1'b1;
    @(negedge clk);
    hash_ready_i = 1'b0;
    chk_eq("pre_byte", 64'(hash_o), 64'h22);
    #2 reset = 1'b1;
    #1;
    chk_eq("ar_hv", 64'(hash_v_o), 0);
    chk_eq("ar_hbyte", 64'(hash_o), 0);
    chk_eq("ar_first", 64'(block_first_o), 0);
    chk_eq("ar_idx", 64'(data_idx_o), 0);
    chk_eq("ar_data", 64'(data_o), 0);
    chk_eq("ar_nn", 64'(nn_o), 0);
    chk_eq("ar_rdy", 64'(ready_o), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    hash_v_i = 1'b1;
    @(negedge clk);
    hash_v_i = 1'b0;
    chk_eq("nn0_ignored", 64'(hash_v_o), 0);
    do_config(8'h00, 8'h04, 8, 64'h0);
    send(DATA, 32'h9);
    chk_eq("post_idx", 64'(data_idx_o), 0);
    chk_eq("post_err", 64'(cfg_err_o), 0);
    hash_v_i = 1'b1;
    @(negedge clk);
    hash_v_i = 1'b0;
    chk_eq("post_hv", 64'(hash_v_o), 1);
    chk_eq("post_byte0", 64'(hash_o), 64'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
